// File: rtl/pe2526_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pe2526_pkg
//  Description : Shared types and constants for the UART memory loader:
//                FSM state encoding, command bytes, error codes, sync marker.
//  Revision    : 1.0  initial release
// ============================================================================
package pe2526_pkg;

   // Loader FSM states, in packet order
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CMD  = 3'd1,
      S_ADDR = 3'd2,
      S_CNT  = 3'd3,
      S_DATA = 3'd4,
      S_CSUM = 3'd5
   } state_t;

   // Command byte values selecting the target memory
   localparam logic [7:0] CMD_MEMA = 8'h01;
   localparam logic [7:0] CMD_MEMB = 8'h02;

   // Error codes reported on err_code
   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_BAD_CMD = 2'd1;
   localparam logic [1:0] ERR_CSUM    = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   // Default packet start marker
   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage : pe2526_pkg
`default_nettype wire

// File: rtl/byte_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : byte_word_packer
//  Description : Packs four bytes (LSB first) into a 32-bit word. The word
//                strobe fires the cycle after the fourth byte, with o_word
//                already holding the completed word.
//  Revision    : 1.0  initial release
// ============================================================================
module byte_word_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_clear,
   input  logic        i_valid,
   input  logic [7:0]  i_byte,
   output logic        o_last_byte,
   output logic        o_word_valid,
   output logic [31:0] o_word
);

   logic [1:0]  r_cnt;
   logic [31:0] r_word;
   logic        r_word_valid;

   // Byte position counter, shift register and one-cycle word strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt        <= 2'd0;
         r_word       <= 32'd0;
         r_word_valid <= 1'b0;
      end else if (i_clear) begin
         r_cnt        <= 2'd0;
         r_word_valid <= 1'b0;
      end else begin
         r_word_valid <= i_valid && (r_cnt == 2'd3);
         if (i_valid) begin
            r_word <= {i_byte, r_word[31:8]};
            r_cnt  <= r_cnt + 2'd1;
         end
      end
   end

   assign o_last_byte  = (r_cnt == 2'd3);
   assign o_word_valid = r_word_valid;
   assign o_word       = r_word;

endmodule : byte_word_packer
`default_nettype wire

// File: rtl/uart_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : uart_mem_loader
//  Description : Parses framed packets from the UART byte stream
//                (SYNC, CMD, ADDR, CNT, data, XOR checksum) and writes the
//                packed 32-bit words into memory A or B. Reports completion
//                or failure as single-cycle done/err pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_mem_loader
   import pe2526_pkg::*;
#(
   parameter int         ADDR_W      = 8,
   parameter int         TIMEOUT_CYC = 100000,
   parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_ready,
   output logic              mem_we,
   output logic              mem_sel,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code
);

   localparam int                c_tmo_w    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYC - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_done_set;
   logic                w_err_set;
   logic [1:0]          w_err_code;

   logic [c_tmo_w-1:0]  r_tmo;
   logic                w_tmo_hit;

   logic                r_sel;
   logic [ADDR_W-1:0]   r_base;
   logic [7:0]          r_cnt;
   logic [7:0]          r_rx_words;
   logic [7:0]          r_csum;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic                r_done;
   logic                r_err;
   logic [1:0]          r_err_code;

   logic                w_pk_valid;
   logic                w_last_byte;
   logic                w_last_word;
   logic                w_word_valid;
   logic [31:0]         w_word;

   assign w_pk_valid  = rx_ready && (r_state == S_DATA);
   assign w_last_word = (r_rx_words == (r_cnt - 8'd1));
   // A byte arriving on the expiry cycle takes priority over the timeout
   assign w_tmo_hit   = (r_state != S_IDLE) && !rx_ready && (r_tmo == c_tmo_last);

   byte_word_packer u_packer (
      .clk          (clk),
      .rst          (rst),
      .i_clear      (r_state == S_IDLE),
      .i_valid      (w_pk_valid),
      .i_byte       (rx_data),
      .o_last_byte  (w_last_byte),
      .o_word_valid (w_word_valid),
      .o_word       (w_word)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state decode plus done/err requests
   always_comb begin
      w_state_nxt = r_state;
      w_done_set  = 1'b0;
      w_err_set   = 1'b0;
      w_err_code  = r_err_code;
      if (w_tmo_hit) begin
         w_state_nxt = S_IDLE;
         w_err_set   = 1'b1;
         w_err_code  = ERR_TIMEOUT;
      end else if (rx_ready) begin
         case (r_state)
            S_IDLE: if (rx_data == SYNC_BYTE) w_state_nxt = S_CMD;
            S_CMD: begin
               if (rx_data == CMD_MEMA || rx_data == CMD_MEMB) begin
                  w_state_nxt = S_ADDR;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_err_set   = 1'b1;
                  w_err_code  = ERR_BAD_CMD;
               end
            end
            S_ADDR: w_state_nxt = S_CNT;
            S_CNT:  w_state_nxt = S_DATA;
            S_DATA: if (w_last_byte && w_last_word) w_state_nxt = S_CSUM;
            S_CSUM: begin
               w_state_nxt = S_IDLE;
               if (rx_data == r_csum) begin
                  w_done_set = 1'b1;
               end else begin
                  w_err_set  = 1'b1;
                  w_err_code = ERR_CSUM;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Inter-byte timeout counter, restarted by every byte and idle in S_IDLE
   always_ff @(posedge clk) begin
      if (rst || r_state == S_IDLE || rx_ready) r_tmo <= '0;
      else                                      r_tmo <= r_tmo + 1'b1;
   end

   // Header capture, checksum accumulation and write-address generation
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sel      <= 1'b0;
         r_base     <= '0;
         r_cnt      <= 8'd0;
         r_rx_words <= 8'd0;
         r_csum     <= 8'd0;
         r_mem_addr <= '0;
      end else if (rx_ready) begin
         case (r_state)
            S_IDLE: begin
               r_csum     <= 8'd0;
               r_rx_words <= 8'd0;
            end
            S_CMD: begin
               r_csum <= r_csum ^ rx_data;
               if (rx_data == CMD_MEMA) r_sel <= 1'b0;
               if (rx_data == CMD_MEMB) r_sel <= 1'b1;
            end
            S_ADDR: begin
               r_csum <= r_csum ^ rx_data;
               r_base <= ADDR_W'(rx_data);
            end
            S_CNT: begin
               r_csum <= r_csum ^ rx_data;
               r_cnt  <= rx_data;
            end
            S_DATA: begin
               r_csum <= r_csum ^ rx_data;
               if (w_last_byte) begin
                  r_mem_addr <= r_base + ADDR_W'(r_rx_words);
                  r_rx_words <= r_rx_words + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Status pulses; err_code only moves when an err pulse fires
   always_ff @(posedge clk) begin
      if (rst) begin
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= ERR_NONE;
      end else begin
         r_done <= w_done_set;
         r_err  <= w_err_set;
         if (w_err_set) r_err_code <= w_err_code;
      end
   end

   assign mem_we    = w_word_valid;
   assign mem_sel   = r_sel;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = w_word;
   assign busy      = (r_state != S_IDLE);
   assign done      = r_done;
   assign err       = r_err;
   assign err_code  = r_err_code;

endmodule : uart_mem_loader
`default_nettype wire
